// File: rtl/ds_dispatch_queue_pkg.sv
// ds_dispatch_queue_pkg
//   Shared pipeline definitions for the dispatch stage.
//   - uop_t        : renamed micro-op record held in the dispatch queue (106 bits)
//   - ALUOP_BUBBLE : ALUop encoding that marks an empty (bubble) bundle slot
//   - SLOTS        : number of slots in a dispatch bundle
//   - slot_valid() : true when a slot carries a real micro-op
package ds_dispatch_queue_pkg;

    localparam int SLOTS = 4;

    localparam logic [8:0] ALUOP_BUBBLE = 9'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [8:0]  aluop;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  rdst;
        logic [5:0]  rsrc1;
        logic [5:0]  rsrc2;
        logic [5:0]  phydst;
        logic [31:0] imm;
    } uop_t;

    function automatic logic slot_valid(input logic [8:0] aluop);
        return aluop != ALUOP_BUBBLE;
    endfunction

endpackage

// File: rtl/ds_slot_compact.sv
// ds_slot_compact
//   Squeezes the valid slots of a 4-wide dispatch bundle down to the low
//   positions, preserving slot order, so they can be written to consecutive
//   queue entries.
//   Ports:
//     slot_in  : bundle as presented, slot 1 at index 0
//     slot_out : valid slots packed from index 0 upward; unused positions are 0
//     count    : number of valid slots (0..4)
module ds_slot_compact
    import ds_dispatch_queue_pkg::*;
(
    input  uop_t [SLOTS-1:0] slot_in,
    output uop_t [SLOTS-1:0] slot_out,
    output logic [2:0]       count
);

    logic [2:0] idx;

    always_comb begin
        slot_out = '0;
        idx      = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_valid(slot_in[i].aluop)) begin
                // idx only reaches 4 after the last slot has been placed
                slot_out[idx[1:0]] = slot_in[i];
                idx                = idx + 3'd1;
            end
        end
        count = idx;
    end

endmodule

// File: rtl/ds_dispatch_queue.sv
// ds_dispatch_queue
//   In-order dispatch queue between rename/dispatch and issue. Accepts a
//   4-slot bundle per cycle (bubbles dropped, survivors compacted) and offers
//   the two oldest entries on two issue ports.
//   Ports:
//     clk, rst            : clock, synchronous active-low reset
//     flush               : synchronous squash of all contents
//     DS_Inst_PC          : PC of slot 1; slot N gets PC + 4*(N-1)
//     DS_InstN_*          : renamed micro-op fields of slot N (N=1..4)
//     Stall               : fewer than 4 free entries; bundle is ignored
//     IssP_valid/ready    : issue handshake for port P (P=0 head, P=1 head+1)
//     IssP_*              : entry fields on port P
//     Occupancy           : number of stored entries
//
//   Handshake: IssP_valid is held while the entry is present and does not
//   depend on IssP_ready. Port 0 transfers when Iss0_valid & Iss0_ready.
//   Port 1 transfers only when port 0 also transfers in that cycle and
//   Iss1_valid & Iss1_ready, so entries always leave in order. Enqueue has no
//   ready input; the producer must hold its bundle while Stall is high.
module ds_dispatch_queue
    import ds_dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ENQ_W = 4,
    parameter int DEQ_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [31:0]              DS_Inst_PC,
    input  logic [8:0]               DS_Inst1_ALUop,
    input  logic [4:0]               DS_Inst1_Src1,
    input  logic [4:0]               DS_Inst1_Src2,
    input  logic [4:0]               DS_Inst1_Rdst,
    input  logic [5:0]               DS_Inst1_RSrc1,
    input  logic [5:0]               DS_Inst1_RSrc2,
    input  logic [5:0]               DS_Inst1_Phydst,
    input  logic [31:0]              DS_Inst1_imm,
    input  logic [8:0]               DS_Inst2_ALUop,
    input  logic [4:0]               DS_Inst2_Src1,
    input  logic [4:0]               DS_Inst2_Src2,
    input  logic [4:0]               DS_Inst2_Rdst,
    input  logic [5:0]               DS_Inst2_RSrc1,
    input  logic [5:0]               DS_Inst2_RSrc2,
    input  logic [5:0]               DS_Inst2_Phydst,
    input  logic [31:0]              DS_Inst2_imm,
    input  logic [8:0]               DS_Inst3_ALUop,
    input  logic [4:0]               DS_Inst3_Src1,
    input  logic [4:0]               DS_Inst3_Src2,
    input  logic [4:0]               DS_Inst3_Rdst,
    input  logic [5:0]               DS_Inst3_RSrc1,
    input  logic [5:0]               DS_Inst3_RSrc2,
    input  logic [5:0]               DS_Inst3_Phydst,
    input  logic [31:0]              DS_Inst3_imm,
    input  logic [8:0]               DS_Inst4_ALUop,
    input  logic [4:0]               DS_Inst4_Src1,
    input  logic [4:0]               DS_Inst4_Src2,
    input  logic [4:0]               DS_Inst4_Rdst,
    input  logic [5:0]               DS_Inst4_RSrc1,
    input  logic [5:0]               DS_Inst4_RSrc2,
    input  logic [5:0]               DS_Inst4_Phydst,
    input  logic [31:0]              DS_Inst4_imm,
    output logic                     Stall,
    output logic                     Iss0_valid,
    input  logic                     Iss0_ready,
    output logic [31:0]              Iss0_PC,
    output logic [8:0]               Iss0_ALUop,
    output logic [4:0]               Iss0_Src1,
    output logic [4:0]               Iss0_Src2,
    output logic [4:0]               Iss0_Rdst,
    output logic [5:0]               Iss0_RSrc1,
    output logic [5:0]               Iss0_RSrc2,
    output logic [5:0]               Iss0_Phydst,
    output logic [31:0]              Iss0_imm,
    output logic                     Iss1_valid,
    input  logic                     Iss1_ready,
    output logic [31:0]              Iss1_PC,
    output logic [8:0]               Iss1_ALUop,
    output logic [4:0]               Iss1_Src1,
    output logic [4:0]               Iss1_Src2,
    output logic [4:0]               Iss1_Rdst,
    output logic [5:0]               Iss1_RSrc1,
    output logic [5:0]               Iss1_RSrc2,
    output logic [5:0]               Iss1_Phydst,
    output logic [31:0]              Iss1_imm,
    output logic [$clog2(DEPTH):0]   Occupancy
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    // Stall once a full bundle might no longer fit
    localparam cnt_t STALL_LIMIT = cnt_t'(DEPTH - ENQ_W);

    uop_t mem [DEPTH];

    ptr_t head;
    ptr_t tail;
    cnt_t occ;

    uop_t [SLOTS-1:0] slot_in;
    uop_t [SLOTS-1:0] slot_cmp;
    logic [2:0]       valid_cnt;

    logic enq_go;
    logic fire0;
    logic fire1;
    cnt_t enq_n;
    cnt_t fire_n;
    uop_t iss0;
    uop_t iss1;

    assign slot_in[0] = '{pc: DS_Inst_PC, aluop: DS_Inst1_ALUop,
                          src1: DS_Inst1_Src1, src2: DS_Inst1_Src2, rdst: DS_Inst1_Rdst,
                          rsrc1: DS_Inst1_RSrc1, rsrc2: DS_Inst1_RSrc2,
                          phydst: DS_Inst1_Phydst, imm: DS_Inst1_imm};
    assign slot_in[1] = '{pc: DS_Inst_PC + 32'd4, aluop: DS_Inst2_ALUop,
                          src1: DS_Inst2_Src1, src2: DS_Inst2_Src2, rdst: DS_Inst2_Rdst,
                          rsrc1: DS_Inst2_RSrc1, rsrc2: DS_Inst2_RSrc2,
                          phydst: DS_Inst2_Phydst, imm: DS_Inst2_imm};
    assign slot_in[2] = '{pc: DS_Inst_PC + 32'd8, aluop: DS_Inst3_ALUop,
                          src1: DS_Inst3_Src1, src2: DS_Inst3_Src2, rdst: DS_Inst3_Rdst,
                          rsrc1: DS_Inst3_RSrc1, rsrc2: DS_Inst3_RSrc2,
                          phydst: DS_Inst3_Phydst, imm: DS_Inst3_imm};
    assign slot_in[3] = '{pc: DS_Inst_PC + 32'd12, aluop: DS_Inst4_ALUop,
                          src1: DS_Inst4_Src1, src2: DS_Inst4_Src2, rdst: DS_Inst4_Rdst,
                          rsrc1: DS_Inst4_RSrc1, rsrc2: DS_Inst4_RSrc2,
                          phydst: DS_Inst4_Phydst, imm: DS_Inst4_imm};

    ds_slot_compact u_compact (
        .slot_in  (slot_in),
        .slot_out (slot_cmp),
        .count    (valid_cnt)
    );

    // Stall looks only at current occupancy, never at this cycle's dequeue
    assign Stall  = occ > STALL_LIMIT;
    assign enq_go = !Stall && !flush;
    assign enq_n  = enq_go ? cnt_t'(valid_cnt) : '0;

    assign Iss0_valid = occ != '0;
    assign Iss1_valid = occ > cnt_t'(1);
    assign fire0      = Iss0_valid && Iss0_ready;
    assign fire1      = fire0 && Iss1_valid && Iss1_ready;
    assign fire_n     = cnt_t'(fire0) + cnt_t'(fire1);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= head + ptr_t'(fire_n);
            tail <= tail + ptr_t'(enq_n);
            occ  <= occ + enq_n - fire_n;
        end
    end

    // Storage carries no reset; occupancy alone decides what is live
    always_ff @(posedge clk) begin
        if (rst && enq_go) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (3'(k) < valid_cnt) begin
                    mem[tail + ptr_t'(k)] <= slot_cmp[k];
                end
            end
        end
    end

    // Pointer arithmetic wraps naturally at DEPTH (power of two)
    assign iss0 = mem[head];
    assign iss1 = mem[head + ptr_t'(DEQ_W - 1)];

    assign Iss0_PC     = iss0.pc;
    assign Iss0_ALUop  = iss0.aluop;
    assign Iss0_Src1   = iss0.src1;
    assign Iss0_Src2   = iss0.src2;
    assign Iss0_Rdst   = iss0.rdst;
    assign Iss0_RSrc1  = iss0.rsrc1;
    assign Iss0_RSrc2  = iss0.rsrc2;
    assign Iss0_Phydst = iss0.phydst;
    assign Iss0_imm    = iss0.imm;

    assign Iss1_PC     = iss1.pc;
    assign Iss1_ALUop  = iss1.aluop;
    assign Iss1_Src1   = iss1.src1;
    assign Iss1_Src2   = iss1.src2;
    assign Iss1_Rdst   = iss1.rdst;
    assign Iss1_RSrc1  = iss1.rsrc1;
    assign Iss1_RSrc2  = iss1.rsrc2;
    assign Iss1_Phydst = iss1.phydst;
    assign Iss1_imm    = iss1.imm;

    assign Occupancy = occ;

endmodule

// File: tb/tb_ds_dispatch_queue.sv
// tb_ds_dispatch_queue
//   Directed and short random stimulus for ds_dispatch_queue, checked against
//   an in-order expected queue of 106-bit records plus hand-computed values.
module tb_ds_dispatch_queue;

    localparam int DEPTH = 16;
    localparam int EW    = 106;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b0;
    logic flush = 1'b0;

    // ---------------- DUT signals ----------------
    logic [31:0] base_pc;
    logic [8:0]  alu  [1:4];
    logic [4:0]  s1   [1:4];
    logic [4:0]  s2   [1:4];
    logic [4:0]  rd   [1:4];
    logic [5:0]  rs1  [1:4];
    logic [5:0]  rs2  [1:4];
    logic [5:0]  pd   [1:4];
    logic [31:0] imm  [1:4];

    logic        Stall;
    logic        Iss0_valid, Iss1_valid;
    logic        Iss0_ready, Iss1_ready;
    logic [31:0] Iss0_PC, Iss1_PC, Iss0_imm, Iss1_imm;
    logic [8:0]  Iss0_ALUop, Iss1_ALUop;
    logic [4:0]  Iss0_Src1, Iss0_Src2, Iss0_Rdst, Iss1_Src1, Iss1_Src2, Iss1_Rdst;
    logic [5:0]  Iss0_RSrc1, Iss0_RSrc2, Iss0_Phydst, Iss1_RSrc1, Iss1_RSrc2, Iss1_Phydst;
    logic [4:0]  Occupancy;

    ds_dispatch_queue #(.DEPTH(DEPTH), .ENQ_W(4), .DEQ_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .DS_Inst_PC(base_pc),
        .DS_Inst1_ALUop(alu[1]), .DS_Inst1_Src1(s1[1]), .DS_Inst1_Src2(s2[1]), .DS_Inst1_Rdst(rd[1]),
        .DS_Inst1_RSrc1(rs1[1]), .DS_Inst1_RSrc2(rs2[1]), .DS_Inst1_Phydst(pd[1]), .DS_Inst1_imm(imm[1]),
        .DS_Inst2_ALUop(alu[2]), .DS_Inst2_Src1(s1[2]), .DS_Inst2_Src2(s2[2]), .DS_Inst2_Rdst(rd[2]),
        .DS_Inst2_RSrc1(rs1[2]), .DS_Inst2_RSrc2(rs2[2]), .DS_Inst2_Phydst(pd[2]), .DS_Inst2_imm(imm[2]),
        .DS_Inst3_ALUop(alu[3]), .DS_Inst3_Src1(s1[3]), .DS_Inst3_Src2(s2[3]), .DS_Inst3_Rdst(rd[3]),
        .DS_Inst3_RSrc1(rs1[3]), .DS_Inst3_RSrc2(rs2[3]), .DS_Inst3_Phydst(pd[3]), .DS_Inst3_imm(imm[3]),
        .DS_Inst4_ALUop(alu[4]), .DS_Inst4_Src1(s1[4]), .DS_Inst4_Src2(s2[4]), .DS_Inst4_Rdst(rd[4]),
        .DS_Inst4_RSrc1(rs1[4]), .DS_Inst4_RSrc2(rs2[4]), .DS_Inst4_Phydst(pd[4]), .DS_Inst4_imm(imm[4]),
        .Stall(Stall),
        .Iss0_valid(Iss0_valid), .Iss0_ready(Iss0_ready), .Iss0_PC(Iss0_PC), .Iss0_ALUop(Iss0_ALUop),
        .Iss0_Src1(Iss0_Src1), .Iss0_Src2(Iss0_Src2), .Iss0_Rdst(Iss0_Rdst), .Iss0_RSrc1(Iss0_RSrc1),
        .Iss0_RSrc2(Iss0_RSrc2), .Iss0_Phydst(Iss0_Phydst), .Iss0_imm(Iss0_imm),
        .Iss1_valid(Iss1_valid), .Iss1_ready(Iss1_ready), .Iss1_PC(Iss1_PC), .Iss1_ALUop(Iss1_ALUop),
        .Iss1_Src1(Iss1_Src1), .Iss1_Src2(Iss1_Src2), .Iss1_Rdst(Iss1_Rdst), .Iss1_RSrc1(Iss1_RSrc1),
        .Iss1_RSrc2(Iss1_RSrc2), .Iss1_Phydst(Iss1_Phydst), .Iss1_imm(Iss1_imm),
        .Occupancy(Occupancy)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [3:0]    cur_mask = 4'h0;
    int            n_checks = 0;
    int            n_fail   = 0;

    wire [EW-1:0] obs0 = {Iss0_PC, Iss0_ALUop, Iss0_Src1, Iss0_Src2, Iss0_Rdst,
                          Iss0_RSrc1, Iss0_RSrc2, Iss0_Phydst, Iss0_imm};
    wire [EW-1:0] obs1 = {Iss1_PC, Iss1_ALUop, Iss1_Src1, Iss1_Src2, Iss1_Rdst,
                          Iss1_RSrc1, Iss1_RSrc2, Iss1_Phydst, Iss1_imm};

    // Record for slot n whose own PC is pc: {pc, aluop, src1, src2, rdst, rsrc1, rsrc2, phydst, imm}
    function automatic logic [EW-1:0] gen_uop(input logic [31:0] pc, input int n);
        logic [8:0]  a;
        logic [4:0]  f_s1, f_s2, f_rd;
        logic [5:0]  f_r1, f_r2, f_pd;
        logic [31:0] f_imm;
        a     = (pc[8:0] ^ 9'(n)) | 9'h100;
        f_s1  = pc[6:2] + 5'(n);
        f_s2  = 5'(n * 3);
        f_rd  = pc[10:6] ^ 5'(n);
        f_r1  = pc[7:2];
        f_r2  = 6'(n + 32);
        f_pd  = pc[8:3] ^ 6'h2A;
        f_imm = (pc ^ 32'hA5A5_0000) + 32'(n);
        return {pc, a, f_s1, f_s2, f_rd, f_r1, f_r2, f_pd, f_imm};
    endfunction

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_bundle(input logic [31:0] pc, input logic [3:0] mask);
        logic [EW-1:0] u;
        base_pc  = pc;
        cur_mask = mask;
        for (int n = 1; n <= 4; n++) begin
            u      = gen_uop(pc + 32'(4 * (n - 1)), n);
            alu[n] = mask[n-1] ? u[73:65] : 9'd0;
            s1[n]  = u[64:60];
            s2[n]  = u[59:55];
            rd[n]  = u[54:50];
            rs1[n] = u[49:44];
            rs2[n] = u[43:38];
            pd[n]  = u[37:32];
            imm[n] = u[31:0];
        end
    endtask

    task automatic clear_bundle();
        set_bundle(32'hDEAD_0000, 4'h0);
    endtask

    // Check outputs against the model, advance the model, then take one edge
    task automatic step();
        int   sz;
        logic m_stall, f0, f1;
        #1;
        sz      = exp_q.size();
        m_stall = (sz > DEPTH - 4);
        chk("occupancy", EW'(Occupancy), EW'(sz));
        chk("stall", EW'(Stall), EW'(m_stall));
        chk("iss0_valid", EW'(Iss0_valid), EW'(sz >= 1));
        chk("iss1_valid", EW'(Iss1_valid), EW'(sz >= 2));
        if (sz >= 1) chk("iss0_entry", obs0, exp_q[0]);
        if (sz >= 2) chk("iss1_entry", obs1, exp_q[1]);
        if (!rst || flush) begin
            exp_q.delete();
        end else begin
            f0 = (sz >= 1) && Iss0_ready;
            f1 = f0 && (sz >= 2) && Iss1_ready;
            if (f0) void'(exp_q.pop_front());
            if (f1) void'(exp_q.pop_front());
            if (!m_stall) begin
                for (int n = 1; n <= 4; n++)
                    if (cur_mask[n-1]) exp_q.push_back(gen_uop(base_pc + 32'(4 * (n - 1)), n));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic r0, input logic r1);
        Iss0_ready = r0;
        Iss1_ready = r1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [EW-1:0] e;
        clear_bundle();
        set_ready(1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_occ", EW'(Occupancy), EW'(0));
        chk("reset_iss0_valid", EW'(Iss0_valid), EW'(0));
        chk("reset_iss1_valid", EW'(Iss1_valid), EW'(0));
        chk("reset_stall", EW'(Stall), EW'(0));
        rst = 1'b1;

        // Full bundle at 0x100 drained two per cycle
        set_ready(1'b1, 1'b1);
        set_bundle(32'h100, 4'hF);
        step();
        clear_bundle();
        chk("t1_occ4", EW'(Occupancy), EW'(4));
        chk("t1_pc0_a", EW'(Iss0_PC), EW'(32'h100));
        chk("t1_pc1_a", EW'(Iss1_PC), EW'(32'h104));
        step();
        chk("t1_occ2", EW'(Occupancy), EW'(2));
        chk("t1_pc0_b", EW'(Iss0_PC), EW'(32'h108));
        chk("t1_pc1_b", EW'(Iss1_PC), EW'(32'h10C));
        step();
        chk("t1_occ0", EW'(Occupancy), EW'(0));

        // Bubbles in slots 2 and 4
        set_ready(1'b0, 1'b0);
        set_bundle(32'h200, 4'b0101);
        chk("t2_no_bypass", EW'(Iss0_valid), EW'(0));
        step();
        clear_bundle();
        e = gen_uop(32'h208, 3);
        chk("t2_occ2", EW'(Occupancy), EW'(2));
        chk("t2_pc0", EW'(Iss0_PC), EW'(32'h200));
        chk("t2_pc1", EW'(Iss1_PC), EW'(32'h208));
        chk("t2_alu1", EW'(Iss1_ALUop), EW'(e[73:65]));
        set_ready(1'b1, 1'b1);
        step();
        chk("t2_drained", EW'(Occupancy), EW'(0));

        // PC wraps modulo 2^32 inside one bundle
        set_bundle(32'hFFFF_FFF8, 4'hF);
        set_ready(1'b0, 1'b0);
        step();
        clear_bundle();
        set_ready(1'b1, 1'b1);
        step();
        chk("pcwrap_pc0", EW'(Iss0_PC), EW'(32'h0));
        chk("pcwrap_pc1", EW'(Iss1_PC), EW'(32'h4));
        step();

        // Port 1 ready alone never fires
        set_ready(1'b0, 1'b0);
        set_bundle(32'h300, 4'b0111);
        step();
        clear_bundle();
        chk("t3_occ3", EW'(Occupancy), EW'(3));
        set_ready(1'b0, 1'b1);
        step();
        chk("t3_hold_occ", EW'(Occupancy), EW'(3));
        chk("t3_hold_pc", EW'(Iss0_PC), EW'(32'h300));
        set_ready(1'b1, 1'b1);
        step();
        chk("t3_occ1", EW'(Occupancy), EW'(1));
        chk("t3_pc_last", EW'(Iss0_PC), EW'(32'h308));
        step();

        // Fill to the stall threshold; stalled bundles are dropped
        set_ready(1'b0, 1'b0);
        set_bundle(32'h400, 4'hF); step();
        set_bundle(32'h410, 4'hF); step();
        set_bundle(32'h420, 4'hF); step();
        chk("t4_occ12", EW'(Occupancy), EW'(12));
        chk("t4_stall12", EW'(Stall), EW'(0));
        set_bundle(32'h430, 4'b0001); step();
        chk("t4_occ13", EW'(Occupancy), EW'(13));
        chk("t4_stall13", EW'(Stall), EW'(1));
        set_bundle(32'h500, 4'hF); step(); step();
        chk("t4_dropped", EW'(Occupancy), EW'(13));
        clear_bundle();
        set_ready(1'b1, 1'b1);
        repeat (7) step();
        chk("t4_drained", EW'(Occupancy), EW'(0));

        // Random enqueue and readiness, order checked by the expected queue
        for (int i = 0; i < 40; i++) begin
            set_bundle({14'd0, 16'($urandom_range(0, 65535)), 2'b00}, 4'($urandom_range(0, 15)));
            set_ready(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        clear_bundle();
        set_ready(1'b1, 1'b1);
        repeat (8) step();
        chk("rand_drained", EW'(Occupancy), EW'(0));

        // Flush with occupancy 9 and a concurrent enqueue
        set_ready(1'b0, 1'b0);
        set_bundle(32'h600, 4'hF); step();
        set_bundle(32'h610, 4'hF); step();
        set_bundle(32'h620, 4'b0001); step();
        chk("t6_occ9", EW'(Occupancy), EW'(9));
        set_bundle(32'h700, 4'hF);
        set_ready(1'b1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_bundle();
        chk("flush_occ", EW'(Occupancy), EW'(0));
        chk("flush_iss0", EW'(Iss0_valid), EW'(0));
        chk("flush_iss1", EW'(Iss1_valid), EW'(0));

        // Reset in the middle of streaming
        set_bundle(32'h800, 4'hF); step();
        set_bundle(32'h810, 4'hF); step();
        set_bundle(32'h820, 4'hF);
        rst = 1'b0;
        step();
        rst = 1'b1;
        clear_bundle();
        chk("rst_occ", EW'(Occupancy), EW'(0));
        chk("rst_iss0", EW'(Iss0_valid), EW'(0));
        chk("rst_iss1", EW'(Iss1_valid), EW'(0));

        // Queue works from the reset pointers
        set_bundle(32'h900, 4'b1000);
        step();
        clear_bundle();
        chk("post_rst_pc", EW'(Iss0_PC), EW'(32'h90C));
        step();
        chk("post_rst_occ", EW'(Occupancy), EW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
